c5_ram_dp: RTL

- Parametrised, dual-port successor to the single-port BSRAM. Two independent byte-enable ports share one inferred block RAM.
- Port A serves the C5 core; port B serves the debug/DMA master.
- The block contains a boot-load engine. After reset, and on request, it copies firmware words from a boot ROM sub-module into the array.
- O_ready gates both ports while a boot load is in progress.

---
 rtl/c5_ram_pkg.sv | 20 ++
 rtl/c5_ram_boot_rom.sv | 36 +++
 rtl/c5_ram_dp.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/c5_ram_pkg.sv
// Shared types and helpers for the dual-port C5 RAM and its boot-load engine.
package c5_ram_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_DRAIN,
    S_RUN
  } state_e;

  // Word index in the array where the first firmware word lands.
  localparam int RAM_INIT_BASE = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/c5_ram_boot_rom.sv
// Firmware boot ROM: one registered read per cycle, latency 1.
module c5_ram_boot_rom #(
  parameter int WIDTH = 32,
  parameter int AW    = 10
) (
  input  logic             I_clk,
  input  logic [AW-1:0]    I_idx,
  output logic [WIDTH-1:0] O_dat
);

  localparam int NBE = WIDTH / 8;

  logic [7:0]       fw_byte;
  logic [WIDTH-1:0] dat_d;
  logic [WIDTH-1:0] dat_q;

  // Generated firmware image: each word is one byte pattern replicated across the lanes.
  always_comb begin
    fw_byte = 8'h00;
    case (I_idx)
      AW'(0):  fw_byte = 8'h11;
      AW'(1):  fw_byte = 8'h22;
      AW'(2):  fw_byte = 8'h33;
      AW'(3):  fw_byte = 8'h44;
      default: fw_byte = 8'h00;
    endcase
    dat_d = {NBE{fw_byte}};
  end

  always_ff @(posedge I_clk) begin
    dat_q <= dat_d;
  end

  assign O_dat = dat_q;

endmodule

// File: rtl/c5_ram_dp.sv
// Dual-port byte-enable RAM shared by the C5 core (port A) and the debug/DMA
// master (port B), with a boot-load engine that fills it from the boot ROM.
module c5_ram_dp
  import c5_ram_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1024,
  parameter int INIT_WORDS = 256
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_reinit,
  output logic                 O_ready,
  input  logic                 I_a_stb,
  input  logic [WIDTH/8-1:0]   I_a_we,
  input  logic [31:0]          I_a_adr,
  input  logic [WIDTH-1:0]     I_a_dat,
  output logic [WIDTH-1:0]     O_a_dat,
  output logic                 O_a_ack,
  output logic                 O_a_err,
  input  logic                 I_b_stb,
  input  logic [WIDTH/8-1:0]   I_b_we,
  input  logic [31:0]          I_b_adr,
  input  logic [WIDTH-1:0]     I_b_dat,
  output logic [WIDTH-1:0]     O_b_dat,
  output logic                 O_b_ack,
  output logic                 O_b_err
);

  localparam int NBE  = WIDTH / 8;
  localparam int ALSB = clog2(NBE);
  localparam int AW   = clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] LAST = CW'((INIT_WORDS == 0) ? 0 : INIT_WORDS - 1);

  state_e           state_d, state_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [CW-1:0]    cnt_prev;
  logic             ready_d, ready_q;
  logic [WIDTH-1:0] rom_dat;
  logic             boot_we;
  logic [AW-1:0]    boot_adr;

  c5_ram_boot_rom #(.WIDTH(WIDTH), .AW(AW)) u_rom (
    .I_clk (I_clk),
    .I_idx (cnt_q[AW-1:0]),
    .O_dat (rom_dat)
  );

  // Boot engine: issue ROM index cnt_q, write the word returned for cnt_q-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        if (INIT_WORDS == 0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_RUN;
      S_RUN: begin
        if (I_reinit) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
    ready_d = (state_d == S_RUN);
  end

  assign cnt_prev = cnt_q - CW'(1);
  assign boot_adr = AW'(RAM_INIT_BASE) + cnt_prev[AW-1:0];
  assign boot_we  = ((state_q == S_INIT) && (cnt_q != '0)) || (state_q == S_DRAIN);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Handshake: a strobe is accepted only in a cycle where O_ready is high; each
  // accepted request gets exactly one ack the following cycle, with read data
  // and err valid alongside it. Strobes seen while O_ready is low are dropped.
  logic          a_acc, a_oor, b_acc, b_oor;
  logic [AW-1:0] a_idx, b_idx;

  assign a_acc = I_a_stb & ready_q;
  assign b_acc = I_b_stb & ready_q;
  assign a_oor = (I_a_adr >> (ALSB + AW)) != 32'd0;
  assign b_oor = (I_b_adr >> (ALSB + AW)) != 32'd0;
  assign a_idx = I_a_adr[ALSB+AW-1:ALSB];
  assign b_idx = I_b_adr[ALSB+AW-1:ALSB];

  logic [WIDTH-1:0] mem [DEPTH];

  // Port A lanes are applied after port B so A wins per byte on a collision.
  always_ff @(posedge I_clk) begin
    if (boot_we) mem[boot_adr] <= rom_dat;
    for (int i = 0; i < NBE; i++) begin
      if (b_acc && !b_oor && I_b_we[i]) mem[b_idx][i*8 +: 8] <= I_b_dat[i*8 +: 8];
      if (a_acc && !a_oor && I_a_we[i]) mem[a_idx][i*8 +: 8] <= I_a_dat[i*8 +: 8];
    end
  end

  logic [WIDTH-1:0] a_dat_d, a_dat_q, b_dat_d, b_dat_q;
  logic             a_err_d, a_err_q, b_err_d, b_err_q;
  logic             a_ack_d, a_ack_q, b_ack_d, b_ack_q;

  always_comb begin
    a_dat_d = a_dat_q;
    a_err_d = a_err_q;
    a_ack_d = a_acc;
    if (a_acc) begin
      a_err_d = a_oor;
      a_dat_d = a_oor ? '0 : mem[a_idx];
    end
    b_dat_d = b_dat_q;
    b_err_d = b_err_q;
    b_ack_d = b_acc;
    if (b_acc) begin
      b_err_d = b_oor;
      b_dat_d = b_oor ? '0 : mem[b_idx];
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      a_dat_q <= '0;
      a_err_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_dat_q <= '0;
      b_err_q <= 1'b0;
      b_ack_q <= 1'b0;
    end else begin
      a_dat_q <= a_dat_d;
      a_err_q <= a_err_d;
      a_ack_q <= a_ack_d;
      b_dat_q <= b_dat_d;
      b_err_q <= b_err_d;
      b_ack_q <= b_ack_d;
    end
  end

  assign O_ready = ready_q;
  assign O_a_dat = a_dat_q;
  assign O_a_err = a_err_q;
  assign O_a_ack = a_ack_q;
  assign O_b_dat = b_dat_q;
  assign O_b_err = b_err_q;
  assign O_b_ack = b_ack_q;

endmodule
